mem_stage_lsu: RTL and testbench

//  Load/store unit for the MEM pipeline stage. Consumes the EX/MEM control word fields (dmem_read, dmem_write, funct3)
//  and the ALU address, then runs one data-memory transaction with a read/write + resp handshake.

---
 rtl/rv32i_types.sv | 27 ++
 rtl/lsu_load_align.sv | 28 ++
 rtl/mem_stage_lsu.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word, mask, funct3 and LSU state types
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - picks the addressed byte/half of a read word and extends it
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the lane addressed by the low address bits, then extend per funct3
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (load_funct3_t'(funct3))
      lb:      data = {{24{byte_lane[7]}}, byte_lane};
      lbu:     data = {24'h000000, byte_lane};
      lh:      data = {{16{half_lane[15]}}, half_lane};
      lhu:     data = {16'h0000, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit; optional MEM_MISALIGN_TRAP_EN
module mem_stage_lsu
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_o
`endif
);

  lsu_state_t     state;
  lsu_state_t     state_next;
  logic           start;
  logic           trap_start;
  logic [1:0]     addr_lo_q;
  logic [2:0]     funct3_q;
  rv32i_word      aligned_data;
  rv32i_mem_wmask st_mask;
  rv32i_word      st_data;

  assign start = valid_i & (dmem_read_i | dmem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;

  // A store wins over a simultaneous read, so alignment is judged by the store size then
  always_comb begin
    trap_start = 1'b0;
    if (dmem_write_i) begin
      case (store_funct3_t'(funct3_i))
        sh:      trap_start = addr_i[0];
        sw:      trap_start = |addr_i[1:0];
        default: trap_start = 1'b0;
      endcase
    end else begin
      case (load_funct3_t'(funct3_i))
        lh, lhu: trap_start = addr_i[0];
        lw:      trap_start = |addr_i[1:0];
        default: trap_start = 1'b0;
      endcase
    end
    trap_start = trap_start & start;
  end

  assign misaligned_o = mis_q;
`else
  assign trap_start = 1'b0;
`endif

  // Byte enables and lane-replicated store data from the incoming access
  always_comb begin
    st_mask = 4'b1111;
    st_data = store_data_i;
    case (store_funct3_t'(funct3_i))
      sb: begin
        st_mask = 4'b0001 << addr_i[1:0];
        st_data = {4{store_data_i[7:0]}};
      end
      sh: begin
        st_mask = 4'b0011 << {addr_i[1], 1'b0};
        st_data = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (aligned_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, pipeline stall and completion pulse
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        stall_o = start;
        if (start) state_next = trap_start ? DONE : BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem_resp) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the access on start, hold the request through BUSY, latch load data on resp
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_address <= '0;
      dmem_wdata   <= '0;
      dmem_wmask   <= 4'b0000;
      load_data_o  <= '0;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_lo_q    <= addr_i[1:0];
            funct3_q     <= funct3_i;
            dmem_address <= {addr_i[31:2], 2'b00};
            if (trap_start) begin
              load_data_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
              mis_q       <= 1'b1;
`endif
            end else begin
              dmem_write <= dmem_write_i;
              dmem_read  <= ~dmem_write_i;
              dmem_wdata <= st_data;
              dmem_wmask <= dmem_write_i ? st_mask : 4'b0000;
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (dmem_read) load_data_o <= aligned_data;
          end
        end
        DONE: begin
`ifdef MEM_MISALIGN_TRAP_EN
          mis_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        dmem_read_i;
  logic        dmem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  mem_stage_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .dmem_read_i  (dmem_read_i),
    .dmem_write_i (dmem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_wmask   (dmem_wmask),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .load_data_o  (load_data_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misaligned_o (misaligned_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic run_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                            input int delay, input logic [31:0] exp_load, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata, input logic exp_mis);
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    int   done_cnt  = 0;
    int   bad       = 0;
    int   exp_busy;
    logic is_load;
    logic [31:0] exp_v;
    is_load  = rd & ~wr;
    exp_busy = exp_mis ? 0 : delay;
    if (is_load || exp_mis) exp_q.push_back(exp_load);
    @(negedge clk);
    valid_i = 1'b1; dmem_read_i = rd; dmem_write_i = wr; funct3_i = f3;
    addr_i = addr; store_data_i = sdata; dmem_resp = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (stall_o) stall_cnt++;
      if (dmem_read || dmem_write) begin
        req_cnt++;
        if (dmem_read !== is_load || dmem_write !== wr || dmem_address !== {addr[31:2], 2'b00} ||
            (wr && (dmem_wmask !== exp_mask || dmem_wdata !== exp_wdata))) bad++;
        dmem_resp  = (req_cnt == delay);
        dmem_rdata = dmem_resp ? rdata : 32'hDEAD_BEEF;
      end else begin
        dmem_resp = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
`ifdef MEM_MISALIGN_TRAP_EN
        tests_run++;
        if (misaligned_o !== exp_mis) begin
          tests_failed++;
          $display("FAIL %s misaligned_o: got %0b want %0b", name, misaligned_o, exp_mis);
        end
`endif
        if (is_load || exp_mis) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: got empty queue want one entry", name);
          end else begin
            exp_v = exp_q.pop_front();
            if (load_data_o !== exp_v) begin
              tests_failed++;
              $display("FAIL %s load_data: got %08h want %08h", name, load_data_o, exp_v);
            end
          end
        end
      end
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    if (done_cnt == 0) exp_q.delete();
    valid_i = 1'b0; dmem_read_i = 1'b0; dmem_write_i = 1'b0; dmem_resp = 1'b0;
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s done pulses: got %0d want 1", name, done_cnt);
    end
    tests_run++;
    if (stall_cnt != exp_busy + 1) begin
      tests_failed++;
      $display("FAIL %s stall cycles: got %0d want %0d", name, stall_cnt, exp_busy + 1);
    end
    tests_run++;
    if (req_cnt != exp_busy || bad != 0) begin
      tests_failed++;
      $display("FAIL %s request: got %0d cycles (%0d unstable) want %0d stable", name, req_cnt, bad, exp_busy);
    end
    #1;
    tests_run++;
    if (done_o !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after done: got done=%0b rd=%0b wr=%0b stall=%0b want all 0",
               name, done_o, dmem_read, dmem_write, stall_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; dmem_read_i = 1'b0; dmem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; store_data_i = 32'h0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({dmem_read, dmem_write, done_o, stall_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset ctrl: got %04b want 0000", {dmem_read, dmem_write, done_o, stall_o});
    end
    tests_run++;
    if (dmem_address !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wmask !== 4'b0000 || load_data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset data: got addr=%08h wdata=%08h mask=%04b load=%08h want zeros",
               dmem_address, dmem_wdata, dmem_wmask, load_data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  f;
    logic [2:0]  fs[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    run_access("lb",  1, 0, 3'd0, 32'h0000_1003, 32'h0, 32'h8899_AABB, 1, 32'hFFFF_FF88, 4'h0, 32'h0, 0);
    run_access("lbu", 1, 0, 3'd4, 32'h0000_1003, 32'h0, 32'h8899_AABB, 1, 32'h0000_0088, 4'h0, 32'h0, 0);
    run_access("lhu", 1, 0, 3'd5, 32'h0000_1002, 32'h0, 32'h8899_AABB, 2, 32'h0000_8899, 4'h0, 32'h0, 0);
    run_access("lh",  1, 0, 3'd1, 32'h0000_1002, 32'h0, 32'h8899_AABB, 1, 32'hFFFF_8899, 4'h0, 32'h0, 0);
    run_access("lw",  1, 0, 3'd2, 32'h0000_1000, 32'h0, 32'h8899_AABB, 3, 32'h8899_AABB, 4'h0, 32'h0, 0);
    for (int i = 0; i < 8; i++) begin
      f = fs[$urandom_range(0, 4)];
      a = $urandom & 32'hFFFF_FFFC;
      if (f == 3'd0 || f == 3'd4) a[1:0] = 2'($urandom_range(0, 3));
      if (f == 3'd1 || f == 3'd5) a[1] = 1'($urandom_range(0, 1));
      w = $urandom;
      run_access("rand_load", 1, 0, f, a, 32'h0, w, $urandom_range(1, 4), ref_load(w, a, f), 4'h0, 32'h0, 0);
    end
  endtask

  task automatic test_stores();
    run_access("lw_pre", 1, 0, 3'd2, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 4'h0, 32'h0, 0);
    run_access("sh", 0, 1, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 2, 32'h0, 4'b1100, 32'hBEEF_BEEF, 0);
    run_access("sh_lo", 0, 1, 3'd1, 32'h0000_1000, 32'h1234_BEEF, 32'h0, 1, 32'h0, 4'b0011, 32'hBEEF_BEEF, 0);
    run_access("sb", 0, 1, 3'd0, 32'h0000_1001, 32'h0000_00A5, 32'h0, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 0);
    run_access("sw", 0, 1, 3'd2, 32'h0000_2004, 32'h1357_9BDF, 32'h0, 5, 32'h0, 4'b1111, 32'h1357_9BDF, 0);
    run_access("rd_wr", 1, 1, 3'd0, 32'h0000_2003, 32'h0000_007E, 32'h0, 1, 32'h0, 4'b1000, 32'h7E7E_7E7E, 0);
    tests_run++;
    if (load_data_o !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL load_hold: got %08h want cafef00d", load_data_o);
    end
  endtask

  task automatic test_non_mem();
    int seen = 0;
    @(negedge clk);
    valid_i = 1'b1; dmem_read_i = 1'b0; dmem_write_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall_o || done_o || dmem_read || dmem_write) seen++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL non_mem: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    run_access("lw_mis", 1, 0, 3'd2, 32'h0000_1001, 32'h0, 32'h8899_AABB, 1, 32'h0, 4'h0, 32'h0, 1);
    run_access("sh_mis", 0, 1, 3'd1, 32'h0000_1003, 32'h1234_5678, 32'h0, 1, 32'h0, 4'h0, 32'h0, 1);
    run_access("lb_ok", 1, 0, 3'd0, 32'h0000_1001, 32'h0, 32'h8899_AABB, 1, 32'hFFFF_FFAA, 4'h0, 32'h0, 0);
`else
    run_access("lw_mis", 1, 0, 3'd2, 32'h0000_1001, 32'h0, 32'h8899_AABB, 1, 32'h8899_AABB, 4'h0, 32'h0, 0);
    run_access("lh_mis", 1, 0, 3'd1, 32'h0000_1003, 32'h0, 32'h8899_AABB, 2, 32'hFFFF_8899, 4'h0, 32'h0, 0);
    run_access("sw_mis", 0, 1, 3'd2, 32'h0000_1002, 32'h0BAD_F00D, 32'h0, 1, 32'h0, 4'b1111, 32'h0BAD_F00D, 0);
`endif
  endtask

  task automatic test_reset_busy();
    int bad = 0;
    @(negedge clk);
    valid_i = 1'b1; dmem_read_i = 1'b1; dmem_write_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h0000_4000;
    @(negedge clk);
    #1;
    tests_run++;
    if (dmem_read !== 1'b1 || stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_busy setup: got rd=%0b stall=%0b want 1 1", dmem_read, stall_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0; dmem_read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dmem_read || dmem_write || done_o || stall_o) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rst_busy idle: got %0d active cycles want 0", bad);
    end
    run_access("lw_after_rst", 1, 0, 3'd2, 32'h0000_4000, 32'h0, 32'h5A5A_1234, 1, 32'h5A5A_1234, 4'h0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_loads();
    test_stores();
    test_misalign();
    test_reset_busy();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
